// File: rtl/serial_nibble_adder_pkg.sv
// Shared types and constants for the serial nibble adder.
//   NIB_W       : width of one processed slice (4 bits)
//   sna_state_t : FSM state encoding (IDLE / BUSY / DONE)
package serial_nibble_adder_pkg;
  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } sna_state_t;
endpackage

// File: rtl/serial_nibble_adder_if.sv
// Handshake bus for serial_nibble_adder.
//   in_valid/in_ready/in_a/in_b/in_cin    : operand channel
//   out_valid/out_ready/out_sum/out_cout  : result channel
//   out_ovf                               : signed overflow, only with SERADD_OVF_EN
// master = operand source / result consumer, slave = the adder.
interface serial_nibble_adder_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
`ifdef SERADD_OVF_EN
  logic             out_ovf;
`endif

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
`ifdef SERADD_OVF_EN
    , input out_ovf
`endif
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout
`ifdef SERADD_OVF_EN
    , output out_ovf
`endif
  );
endinterface

// File: rtl/serial_nibble_adder_nib_add4.sv
// Combinational 4-bit ripple-carry adder.
//   a, b : addend nibbles      c  : carry in
//   s    : sum nibble          co : carry out of bit 3
//   c3   : carry into bit 3 (used for signed overflow detection)
module nib_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);
  logic [4:0] cc;

  assign cc[0] = c;
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign s[i]    = a[i] ^ b[i] ^ cc[i];
    assign cc[i+1] = (a[i] & b[i]) | (cc[i] & (a[i] ^ b[i]));
  end

  assign co = cc[4];
  assign c3 = cc[3];
endmodule

// File: rtl/serial_nibble_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock, LSB nibble first, through a
// single 4-bit ripple adder with the carry held in a flop between nibbles.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : serial_nibble_adder_if.slave (operand and result handshakes)
// Optional feature: define SERADD_OVF_EN to produce bus.out_ovf (signed overflow).
// Latency NIB=WIDTH/4 clocks from accept to out_valid; one add per NIB+2 cycles.
module serial_nibble_adder
  import serial_nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_nibble_adder_if.slave bus
);
  localparam int NIB   = WIDTH / NIB_W;
  localparam int CNT_W = $clog2(NIB);

  sna_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic             carry, cout_r;
  logic [3:0]       nib_s;
  logic             nib_co;
  logic             accept, last;

  assign accept = bus.in_valid && (state == ST_IDLE);
  assign last   = (cnt == CNT_W'(NIB - 1));

`ifdef SERADD_OVF_EN
  logic nib_c3, ovf_r;
`else
  logic c3_unused;
`endif

  nib_add4 u_add (
    .a  (a_sh[NIB_W-1:0]),
    .b  (b_sh[NIB_W-1:0]),
    .c  (carry),
    .s  (nib_s),
    .co (nib_co),
`ifdef SERADD_OVF_EN
    .c3 (nib_c3)
`else
    .c3 (c3_unused)
`endif
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)        state_nxt = ST_BUSY;
      ST_BUSY: if (last)          state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  // outputs: in_ready only in IDLE, so no same-cycle bypass out of DONE
  always_comb begin
    bus.in_ready  = (state == ST_IDLE);
    bus.out_valid = (state == ST_DONE);
  end

  // datapath: operand shifters, carry flop, nibble counter, result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      cnt    <= '0;
`ifdef SERADD_OVF_EN
      ovf_r  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          a_sh  <= bus.in_a;
          b_sh  <= bus.in_b;
          carry <= bus.in_cin;
          cnt   <= '0;
        end
        ST_BUSY: begin
          // sum nibbles enter from the top so the LSB nibble lands at [3:0] last
          sum_sh <= {nib_s, sum_sh[WIDTH-1:NIB_W]};
          a_sh   <= a_sh >> NIB_W;
          b_sh   <= b_sh >> NIB_W;
          carry  <= nib_co;
          cnt    <= cnt + 1'b1;
          if (last) begin
            cout_r <= nib_co;
`ifdef SERADD_OVF_EN
            ovf_r  <= nib_c3 ^ nib_co;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_sum  = sum_sh;
  assign bus.out_cout = cout_r;
`ifdef SERADD_OVF_EN
  assign bus.out_ovf  = ovf_r;
`endif
endmodule

// File: tb/tb_serial_nibble_adder.sv
module tb_serial_nibble_adder;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  typedef struct {
    logic [15:0] a, b;
    logic        cin;
    logic [15:0] sum;
    logic        cout, ovf;
    int          hold;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic        cout, ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_nibble_adder_if #(.WIDTH(WIDTH)) bus ();
  serial_nibble_adder #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_add(input vec_t v);
    exp_t e, got;
    int   lat;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = v.a;
    bus.in_b     = v.b;
    bus.in_cin   = v.cin;
    @(posedge clk); #1;
    e.sum = v.sum; e.cout = v.cout; e.ovf = v.ovf;
    sb.push_back(e);
    // junk operands held valid while busy must be ignored
    bus.in_a   = ~v.a;
    bus.in_b   = 16'h5A5A;
    bus.in_cin = ~v.cin;
    chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, NIB);
    if (!bus.out_valid) begin
      $display("FAIL timeout: out_valid never rose for a=%h b=%h", v.a, v.b);
      errors++;
      bus.in_valid = 1'b0;
      sb.delete();
      return;
    end
    for (int i = 0; i < v.hold; i++) begin
      chk("hold_sum", 32'(bus.out_sum), 32'(sb[0].sum));
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    got = sb.pop_front();
    chk("sum", 32'(bus.out_sum), 32'(got.sum));
    chk("cout", 32'(bus.out_cout), 32'(got.cout));
`ifdef SERADD_OVF_EN
    chk("ovf", 32'(bus.out_ovf), 32'(got.ovf));
`endif
    chk("hs_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("post_valid", 32'(bus.out_valid), 32'd0);
    chk("post_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1};
    tbl[2] = '{16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0, 5};
    tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 2};
    tbl[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 0};
    tbl[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum", 32'(bus.out_sum), 32'd0);
    chk("rst_cout", 32'(bus.out_cout), 32'd0);
`ifdef SERADD_OVF_EN
    chk("rst_ovf", 32'(bus.out_ovf), 32'd0);
`endif
    rst = 1'b0;

    foreach (tbl[i]) run_add(tbl[i]);

    // random operands against a behavioural model
    for (int i = 0; i < 8; i++) begin
      vec_t v;
      logic [16:0] t;
      v.a   = 16'($urandom);
      v.b   = 16'($urandom);
      v.cin = 1'($urandom_range(0, 1));
      t     = {1'b0, v.a} + {1'b0, v.b} + 17'(v.cin);
      v.sum  = t[15:0];
      v.cout = t[16];
      v.ovf  = (v.a[15] == v.b[15]) && (t[15] != v.a[15]);
      v.hold = int'($urandom_range(0, 3));
      run_add(v);
    end

    // reset after two busy cycles discards the add
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_a = 16'h1234; bus.in_b = 16'h1111; bus.in_cin = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_sum", 32'(bus.out_sum), 32'd0);
    chk("mrst_cout", 32'(bus.out_cout), 32'd0);
`ifdef SERADD_OVF_EN
    chk("mrst_ovf", 32'(bus.out_ovf), 32'd0);
`endif
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("mrst_no_valid", 32'(bus.out_valid), 32'd0);
    end

    // still functional after the mid-add reset
    run_add(tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
